// File: rtl/lcd_win_pkg.sv
// lcd_win_pkg
// Shared definitions for the LCD window controller: host command codes and
// the controller FSM state encoding.
package lcd_win_pkg;

    localparam logic [2:0] CMD_REFLASH  = 3'd0;
    localparam logic [2:0] CMD_LOAD     = 3'd1;
    localparam logic [2:0] CMD_RIGHT    = 3'd2;
    localparam logic [2:0] CMD_LEFT     = 3'd3;
    localparam logic [2:0] CMD_UP       = 3'd4;
    localparam logic [2:0] CMD_DOWN     = 3'd5;
    localparam logic [2:0] CMD_MIRROR_X = 3'd6;
    localparam logic [2:0] CMD_MIRROR_Y = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_DISPLAY = 2'd3
    } state_t;

endpackage

// File: rtl/lcd_img_buf.sv
// lcd_img_buf
// Image store for the LCD window controller. One synchronous write port and
// one asynchronous read port; the consumer registers the read data.
// Ports:
//   clk      rising-edge clock
//   i_we     write enable
//   i_waddr  write address (row*IMG_W+col)
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational)
module lcd_img_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 36,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl
// LCD window controller: holds one IMG_W x IMG_H image loaded serially and,
// per host command, streams a WIN x WIN window (optionally mirrored in x
// and/or y) in raster order.
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   datain        pixel stream during Load, raster order
//   cmd           command code (see lcd_win_pkg)
//   cmd_valid     command strobe, honoured only while busy=0
//   dataout       window pixel, registered
//   output_valid  dataout qualifier
//   busy          high while a command is in progress
module lcd_win_ctrl
    import lcd_win_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N  = IMG_W * IMG_H;
    localparam int AW = (N > 1)     ? $clog2(N)     : 1;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WW = (WIN > 1)   ? $clog2(WIN)   : 1;

    localparam logic [XW-1:0] X_DEF  = XW'((IMG_W - WIN) / 2);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] Y_DEF  = YW'((IMG_H - WIN) / 2);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - WIN);
    localparam logic [WW-1:0] W_LAST = WW'(WIN - 1);
    localparam logic [AW-1:0] K_LAST = AW'(N - 1);

    state_t        r_state, w_state_n;
    logic [2:0]    r_cmd, w_cmd_n;
    logic [XW-1:0] r_x0, w_x0_n;
    logic [YW-1:0] r_y0, w_y0_n;
    logic          r_mx, w_mx_n;
    logic          r_my, w_my_n;
    logic [AW-1:0] r_k, w_k_n;
    logic [WW-1:0] r_r, w_r_n;
    logic [WW-1:0] r_c, w_c_n;
    logic          r_valid;
    logic [DW-1:0] r_dout;

    logic          w_issue;
    logic          w_we;
    logic [WW-1:0] w_wr, w_wc;
    logic [YW-1:0] w_srow;
    logic [XW-1:0] w_scol;
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] w_pix;

    // Next-state logic. w_issue marks a cycle that fetches the pixel shown in
    // the following cycle; the fetch uses the *next* window position, mirror
    // flags and window index so the first DISPLAY cycle already sees the
    // updated window.
    always_comb begin
        w_state_n = r_state;
        w_cmd_n   = r_cmd;
        w_x0_n    = r_x0;
        w_y0_n    = r_y0;
        w_mx_n    = r_mx;
        w_my_n    = r_my;
        w_k_n     = r_k;
        w_r_n     = r_r;
        w_c_n     = r_c;
        w_issue   = 1'b0;
        w_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_cmd_n   = cmd;
                    w_k_n     = '0;
                    w_state_n = (cmd == CMD_LOAD) ? ST_LOAD : ST_UPDATE;
                end
            end
            ST_LOAD: begin
                w_we  = 1'b1;
                w_k_n = r_k + 1'b1;
                if (r_k == K_LAST) begin
                    w_x0_n    = X_DEF;
                    w_y0_n    = Y_DEF;
                    w_mx_n    = 1'b0;
                    w_my_n    = 1'b0;
                    w_r_n     = '0;
                    w_c_n     = '0;
                    w_issue   = 1'b1;
                    w_state_n = ST_DISPLAY;
                end
            end
            ST_UPDATE: begin
                case (r_cmd)
                    CMD_RIGHT:    if (r_x0 < X_MAX) w_x0_n = r_x0 + 1'b1;
                    CMD_LEFT:     if (r_x0 != '0)   w_x0_n = r_x0 - 1'b1;
                    CMD_UP:       if (r_y0 != '0)   w_y0_n = r_y0 - 1'b1;
                    CMD_DOWN:     if (r_y0 < Y_MAX) w_y0_n = r_y0 + 1'b1;
                    CMD_MIRROR_X: w_mx_n = ~r_mx;
                    CMD_MIRROR_Y: w_my_n = ~r_my;
                    default:      ;
                endcase
                w_r_n     = '0;
                w_c_n     = '0;
                w_issue   = 1'b1;
                w_state_n = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (r_r == W_LAST && r_c == W_LAST) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_issue = 1'b1;
                    if (r_c == W_LAST) begin
                        w_c_n = '0;
                        w_r_n = r_r + 1'b1;
                    end else begin
                        w_c_n = r_c + 1'b1;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Source coordinate of the pixel being fetched.
    assign w_wr    = w_my_n ? (W_LAST - w_r_n) : w_r_n;
    assign w_wc    = w_mx_n ? (W_LAST - w_c_n) : w_c_n;
    assign w_srow  = w_y0_n + YW'(w_wr);
    assign w_scol  = w_x0_n + XW'(w_wc);
    assign w_raddr = AW'(32'(w_srow) * IMG_W + 32'(w_scol));

    lcd_img_buf #(
        .DW    (DW),
        .DEPTH (N),
        .AW    (AW)
    ) u_img_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_k),
        .i_wdata (datain),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // The last Load cycle writes and fetches in the same cycle; forward the
    // incoming pixel when the first window pixel is the one being written.
    assign w_pix = (w_we && (r_k == w_raddr)) ? datain : w_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_REFLASH;
            r_x0    <= X_DEF;
            r_y0    <= Y_DEF;
            r_mx    <= 1'b0;
            r_my    <= 1'b0;
            r_k     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_n;
            r_cmd   <= w_cmd_n;
            r_x0    <= w_x0_n;
            r_y0    <= w_y0_n;
            r_mx    <= w_mx_n;
            r_my    <= w_my_n;
            r_k     <= w_k_n;
            r_r     <= w_r_n;
            r_c     <= w_c_n;
            r_valid <= w_issue;
            if (w_issue) begin
                r_dout <= w_pix;
            end
        end
    end

    assign dataout      = r_dout;
    assign output_valid = r_valid;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// tb_lcd_win_ctrl
// Drives two controller instances (6x6/WIN=3 and 8x4/WIN=2) with directed and
// random command sequences and compares every cycle of each command against a
// behavioural window model.
module tb_lcd_win_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] datain;
    logic [2:0] cmd;
    logic       cv;
    logic       sel;
    logic       cv0, cv1;
    logic [7:0] do0, do1, dout;
    logic       ov0, ov1, ov;
    logic       bz0, bz1, bz;

    always #5 clk = ~clk;

    assign cv0  = cv & ~sel;
    assign cv1  = cv & sel;
    assign dout = sel ? do1 : do0;
    assign ov   = sel ? ov1 : ov0;
    assign bz   = sel ? bz1 : bz0;

    lcd_win_ctrl #(.DW(8), .IMG_W(6), .IMG_H(6), .WIN(3)) u_dut0 (
        .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cv0),
        .dataout(do0), .output_valid(ov0), .busy(bz0)
    );

    lcd_win_ctrl #(.DW(8), .IMG_W(8), .IMG_H(4), .WIN(2)) u_dut1 (
        .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cv1),
        .dataout(do1), .output_valid(ov1), .busy(bz1)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    int W, H, WN;
    int img [64];
    bit img_ok;
    int x0, y0;
    bit mx, my;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_defaults();
        x0 = (W - WN) / 2;
        y0 = (H - WN) / 2;
        mx = 1'b0;
        my = 1'b0;
    endtask

    function automatic int exp_pix(input int i);
        int r, c, sr, sc;
        r  = i / WN;
        c  = i % WN;
        sr = y0 + (my ? (WN - 1 - r) : r);
        sc = x0 + (mx ? (WN - 1 - c) : c);
        return img[sr * W + sc];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        cv    = 1'b0;
        tick();
        chk("rst_busy", bz, 0);
        chk("rst_valid", ov, 0);
        chk("rst_dout", dout, 0);
        reset = 1'b0;
        model_defaults();
        img_ok = 1'b0;
    endtask

    // c: command; pat: 0 -> pixel k = k, 1 -> random pixels;
    // noise: 0 none, 1 random cmd_valid/cmd while busy, 2 Down held while busy;
    // rst_at: Load pixel index at which reset is asserted (-1 for none).
    task automatic run_cmd(input int c, input int pat, input int noise, input int rst_at);
        int n, pix;
        n = 0;
        while (bz !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
        cmd = 3'(c);
        cv  = 1'b1;
        tick();
        cv = 1'b0;
        chk("acc_busy", bz, 1);
        chk("acc_valid", ov, 0);
        if (c == 1) begin
            for (int k = 0; k < W * H; k++) begin
                if (k == rst_at) begin
                    reset = 1'b1;
                    tick();
                    chk("mid_rst_busy", bz, 0);
                    chk("mid_rst_valid", ov, 0);
                    chk("mid_rst_dout", dout, 0);
                    reset = 1'b0;
                    model_defaults();
                    img_ok = 1'b0;
                    return;
                end
                pix    = (pat == 0) ? k : int'($urandom_range(0, 255));
                datain = 8'(pix);
                img[k] = pix;
                if (noise != 0) begin
                    cv  = 1'($urandom_range(0, 1));
                    cmd = 3'($urandom_range(0, 7));
                end
                chk("load_busy", bz, 1);
                chk("load_valid", ov, 0);
                tick();
            end
            cv = 1'b0;
            model_defaults();
            img_ok = 1'b1;
        end else begin
            case (c)
                2: if (x0 < W - WN) x0++;
                3: if (x0 > 0) x0--;
                4: if (y0 > 0) y0--;
                5: if (y0 < H - WN) y0++;
                6: mx = !mx;
                7: my = !my;
                default: ;
            endcase
            tick();
        end
        for (int i = 0; i < WN * WN; i++) begin
            chk("disp_valid", ov, 1);
            chk("disp_busy", bz, 1);
            if (img_ok) chk("disp_pixel", dout, exp_pix(i));
            if (noise == 1) begin
                cv  = 1'($urandom_range(0, 1));
                cmd = 3'($urandom_range(0, 7));
            end else if (noise == 2) begin
                cv  = 1'b1;
                cmd = 3'd5;
            end
            tick();
        end
        cv = 1'b0;
        chk("end_busy", bz, 0);
        chk("end_valid", ov, 0);
    endtask

    initial begin
        sel    = 1'b0;
        reset  = 1'b1;
        cv     = 1'b0;
        cmd    = 3'd0;
        datain = 8'd0;
        W = 6; H = 6; WN = 3;
        model_defaults();
        img_ok = 1'b0;
        tick();
        tick();
        chk("rst0_busy", bz0, 0);
        chk("rst0_valid", ov0, 0);
        chk("rst0_dout", do0, 0);
        chk("rst1_busy", bz1, 0);
        chk("rst1_valid", ov1, 0);
        chk("rst1_dout", do1, 0);
        reset = 1'b0;

        // 6x6, WIN=3
        run_cmd(1, 0, 0, -1);
        chk("first_pixel_const", img[7], 7);
        run_cmd(2, 0, 0, -1);
        run_cmd(2, 0, 0, -1);
        run_cmd(2, 0, 0, -1);
        run_cmd(4, 0, 0, -1);
        run_cmd(4, 0, 0, -1);
        run_cmd(1, 0, 0, -1);
        run_cmd(6, 0, 0, -1);
        run_cmd(7, 0, 0, -1);
        run_cmd(0, 0, 0, -1);
        run_cmd(1, 0, 0, -1);
        run_cmd(0, 0, 2, -1);
        run_cmd(0, 0, 0, -1);
        run_cmd(1, 0, 0, 10);
        run_cmd(1, 1, 0, -1);
        run_cmd(3, 0, 0, -1);
        run_cmd(3, 0, 0, -1);
        run_cmd(5, 0, 0, -1);
        run_cmd(5, 0, 0, -1);
        run_cmd(5, 0, 0, -1);
        for (int j = 0; j < 60; j++) begin
            int c;
            c = int'($urandom_range(0, 7));
            run_cmd(c, 1, 1, -1);
        end

        // 8x4, WIN=2
        sel = 1'b1;
        W = 8; H = 4; WN = 2;
        do_reset();
        run_cmd(1, 0, 0, -1);
        run_cmd(5, 0, 0, -1);
        run_cmd(5, 0, 0, -1);
        run_cmd(2, 0, 0, -1);
        run_cmd(6, 0, 0, -1);
        for (int j = 0; j < 40; j++) begin
            int c;
            c = int'($urandom_range(0, 7));
            run_cmd(c, 1, 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", nvec);
        $fatal(1, "watchdog");
    end

endmodule
